// File: rtl/seq_div_if.sv
// Handshake and data bundle for the sequential signed divider.
// The master drives the operands and start; the slave returns the result and flags.
interface seq_div_if;
  logic       start;
  logic [7:0] Z;
  logic [3:0] Y;
  logic [7:0] Q;
  logic [3:0] R;
  logic       valid;
  logic       busy;
  logic       dbz;
  logic       ovf;

  modport master (
    output start, Z, Y,
    input  Q, R, valid, busy, dbz, ovf
  );

  modport slave (
    input  start, Z, Y,
    output Q, R, valid, busy, dbz, ovf
  );
endinterface

// File: rtl/seq_div.sv
// Sequential signed 8/4 divider, restoring algorithm on magnitudes.
// Fixed latency: result is valid 9 cycles after the start sample.
module seq_div (
  input logic    clk,
  input logic    rst,
  seq_div_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t     st;
  logic [2:0] cnt;
  logic [7:0] dvd;
  logic [4:0] rem;
  logic [3:0] ay;
  logic       sz;
  logic       sy;
  logic       yz;
  logic       mn;

  logic [4:0] cand;
  logic [4:0] diff;
  logic       ge;

  // Next partial remainder after shifting in the dividend MSB.
  assign cand = {rem[3:0], dvd[7]};
  assign ge   = cand >= {1'b0, ay};
  assign diff = cand - {1'b0, ay};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= 3'd0;
      dvd       <= 8'h00;
      rem       <= 5'd0;
      ay        <= 4'h0;
      sz        <= 1'b0;
      sy        <= 1'b0;
      yz        <= 1'b0;
      mn        <= 1'b0;
      bus.Q     <= 8'h00;
      bus.R     <= 4'h0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.dbz   <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            sz       <= bus.Z[7];
            sy       <= bus.Y[3];
            dvd      <= bus.Z[7] ? 8'(-bus.Z) : bus.Z;
            ay       <= bus.Y[3] ? 4'(-bus.Y) : bus.Y;
            yz       <= bus.Y == 4'h0;
            mn       <= (bus.Z == 8'h80) && (bus.Y == 4'hF);
            rem      <= 5'd0;
            cnt      <= 3'd0;
            bus.busy <= 1'b1;
            st       <= CALC;
          end
        end
        CALC: begin
          if (ge) begin
            rem <= diff;
            dvd <= {dvd[6:0], 1'b1};
          end else begin
            rem <= cand;
            dvd <= {dvd[6:0], 1'b0};
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7)
            st <= FIX;
        end
        FIX: begin
          if (yz) begin
            bus.Q <= 8'h00;
            bus.R <= 4'h0;
          end else begin
            bus.Q <= (sz ^ sy) ? 8'(-dvd) : dvd;
            bus.R <= sz ? 4'(-rem) : rem[3:0];
          end
          bus.dbz   <= yz;
          bus.ovf   <= mn;
          bus.valid <= 1'b1;
          bus.busy  <= 1'b0;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Randomized self-checking bench for seq_div.
// Expected results come from plain signed integer division.
module tb_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seq_div_if bus ();

  seq_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] z, input logic [3:0] y,
                                output logic [7:0] q, output logic [3:0] r,
                                output logic d, output logic o);
    int zi, yi, qi, ri;
    zi = int'($signed(z));
    yi = int'($signed(y));
    if (yi == 0) begin
      q = 8'h00; r = 4'h0; d = 1'b1; o = 1'b0;
    end else begin
      qi = zi / yi;
      ri = zi % yi;
      q  = 8'(qi);
      r  = 4'(ri);
      d  = 1'b0;
      o  = (zi == -128) && (yi == -1);
    end
  endfunction

  task automatic run_op(input logic [7:0] z, input logic [3:0] y,
                        input int poke, input string tag);
    logic [7:0] eq, gq;
    logic [3:0] er, gr;
    logic       ed, eo, gd, go;
    int         lat, pulses;
    model(z, y, eq, er, ed, eo);
    gq = '0; gr = '0; gd = 1'b0; go = 1'b0;
    lat = 0; pulses = 0;
    @(negedge clk);
    bus.Z = z; bus.Y = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.Z = 8'($urandom);
    bus.Y = 4'($urandom);
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    for (int c = 1; c <= 16; c++) begin
      bus.start = (c == poke);
      if (c == poke) begin
        bus.Z = 8'($urandom);
        bus.Y = 4'($urandom);
      end
      @(negedge clk);
      if (bus.valid) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          gq = bus.Q; gr = bus.R; gd = bus.dbz; go = bus.ovf;
        end
      end
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, 32'(lat), 32'd9);
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".Q"}, 32'(gq), 32'(eq));
    check({tag, ".R"}, 32'(gr), 32'(er));
    check({tag, ".dbz"}, 32'(gd), 32'(ed));
    check({tag, ".ovf"}, 32'(go), 32'(eo));
    check({tag, ".holdQ"}, 32'(bus.Q), 32'(eq));
    check({tag, ".idle"}, 32'(bus.busy), 32'd0);
  endtask

  logic [7:0] zq[$];
  logic [3:0] yq[$];

  initial begin
    int pulses;
    logic [7:0] eq, pz;
    logic [3:0] er, py;
    logic       ed, eo;

    bus.start = 1'b0;
    bus.Z = 8'h00;
    bus.Y = 4'h0;
    repeat (2) @(negedge clk);
    check("rst.Q", 32'(bus.Q), 32'd0);
    check("rst.R", 32'(bus.R), 32'd0);
    check("rst.valid", 32'(bus.valid), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.dbz", 32'(bus.dbz), 32'd0);
    check("rst.ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(8'd100, 4'd7, 0, "p100_7");
    check("p100_7.Qk", 32'(bus.Q), 32'd14);
    check("p100_7.Rk", 32'(bus.R), 32'd2);
    run_op(8'h9C, 4'd7, 0, "m100_7");
    check("m100_7.Qk", 32'(bus.Q), 32'hF2);
    check("m100_7.Rk", 32'(bus.R), 32'hE);
    run_op(8'd100, 4'h8, 0, "p100_m8");
    check("p100_m8.Qk", 32'(bus.Q), 32'hF4);
    check("p100_m8.Rk", 32'(bus.R), 32'h4);
    run_op(8'h80, 4'hF, 0, "ovf");
    check("ovf.flag", 32'(bus.ovf), 32'd1);
    check("ovf.Qk", 32'(bus.Q), 32'h80);
    run_op(8'd55, 4'h0, 0, "dbz");
    check("dbz.flag", 32'(bus.dbz), 32'd1);
    run_op(8'd20, 4'd3, 4, "ignore");
    check("ignore.Qk", 32'(bus.Q), 32'd6);

    // Abort an operation part way through CALC.
    @(negedge clk);
    bus.Z = 8'd77; bus.Y = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort.Q", 32'(bus.Q), 32'd0);
    check("abort.R", 32'(bus.R), 32'd0);
    check("abort.valid", 32'(bus.valid), 32'd0);
    check("abort.busy0", 32'(bus.busy), 32'd0);
    check("abort.dbz", 32'(bus.dbz), 32'd0);
    check("abort.ovf", 32'(bus.ovf), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      if (bus.valid) pulses++;
    end
    check("abort.novalid", 32'(pulses), 32'd0);
    run_op(8'd9, 4'd2, 0, "after_rst");
    check("after_rst.Qk", 32'(bus.Q), 32'd4);
    check("after_rst.Rk", 32'(bus.R), 32'd1);

    for (int i = 0; i < 20; i++)
      run_op(8'($urandom), 4'($urandom), 0, $sformatf("rnd%0d", i));

    // Start held high: a new operation is sampled every 10 cycles.
    @(negedge clk);
    for (int j = 0; j <= 50; j++) begin
      if (j > 0) begin
        check($sformatf("b2b.valid%0d", j), 32'(bus.valid),
              32'(j % 10 == 0));
        if (j % 10 == 0) begin
          if (zq.size() == 0) begin
            check("b2b.empty", 32'd1, 32'(zq.size()));
          end else begin
            pz = zq.pop_front();
            py = yq.pop_front();
            model(pz, py, eq, er, ed, eo);
            check($sformatf("b2b.Q%0d", j), 32'(bus.Q), 32'(eq));
            check($sformatf("b2b.R%0d", j), 32'(bus.R), 32'(er));
            check($sformatf("b2b.dbz%0d", j), 32'(bus.dbz), 32'(ed));
            check($sformatf("b2b.ovf%0d", j), 32'(bus.ovf), 32'(eo));
          end
        end
      end
      if (j == 50) begin
        bus.start = 1'b0;
      end else begin
        bus.start = 1'b1;
        bus.Z = 8'($urandom);
        bus.Y = 4'($urandom);
        if (j % 10 == 0) begin
          zq.push_back(bus.Z);
          yq.push_back(bus.Y);
        end
      end
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    check("b2b.drained", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
